// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared 7-segment codes, converter states and nibble decoder
// Contents:
//   SEG_0..SEG_9, SEG_BLANK, SEG_DASH : active-low segment codes, [7]=dp
//   BIN_BITS                          : width of the binary value converted to BCD
//   RESULT_MAX                        : largest result shown as digits
//   cv_state_t                        : converter FSM states
//   nibble_to_seg()                   : BCD nibble to segment code, >9 blanks
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // 14 bits is the smallest width that holds 9999.
  localparam int          BIN_BITS   = 14;
  localparam logic [31:0] RESULT_MAX = 32'd9999;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_SHIFT,
    CV_DONE
  } cv_state_t;

  function automatic logic [7:0] nibble_to_seg(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd.sv
// rtl/seg_scan_display_bin2bcd.sv - sequential double-dabble binary to BCD converter
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load bin and begin conversion (honoured only when idle)
//   bin        : BIN_BITS-bit unsigned value, must be <= 9999
//   busy       : converter not idle
//   done       : one-cycle pulse, bcd is valid while high
//   bcd        : four BCD digits, [15:12] most significant
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_BITS-1:0] bin,
  output logic                busy,
  output logic                done,
  output logic [15:0]         bcd
);

  localparam int SR_W = 16 + BIN_BITS;
  localparam logic [3:0] LAST_ITER = 4'(BIN_BITS - 1);

  cv_state_t       state, state_d;
  logic [3:0]      iter, iter_d;
  logic [SR_W-1:0] sr, sr_d;

  // One double-dabble step: correct each BCD nibble that would exceed 9
  // after doubling, then shift the whole register left by one.
  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[BIN_BITS + 4*i +: 4] >= 4'd5)
        t[BIN_BITS + 4*i +: 4] = t[BIN_BITS + 4*i +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CV_IDLE;
      iter  <= '0;
      sr    <= '0;
    end else begin
      state <= state_d;
      iter  <= iter_d;
      sr    <= sr_d;
    end
  end

  always_comb begin
    state_d = state;
    iter_d  = iter;
    sr_d    = sr;
    case (state)
      CV_IDLE: begin
        if (start) begin
          sr_d    = {16'h0000, bin};
          iter_d  = '0;
          state_d = CV_SHIFT;
        end
      end
      CV_SHIFT: begin
        sr_d   = dabble(sr);
        iter_d = iter + 4'd1;
        if (iter == LAST_ITER)
          state_d = CV_DONE;
      end
      CV_DONE: state_d = CV_IDLE;
      default: state_d = CV_IDLE;
    endcase
  end

  assign busy = (state != CV_IDLE);
  assign done = (state == CV_DONE);
  assign bcd  = sr[SR_W-1:BIN_BITS];

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - Basys3 4-digit 7-segment scanner for entry and GCD result
// Ports:
//   clk, rst_n   : 100 MHz clock, asynchronous active-low reset
//   entry_bcd    : entry digits, [15:12]=digit3 (leftmost) .. [3:0]=digit0
//   cursor       : digit under edit, 0=rightmost
//   result       : GCD result, unsigned binary
//   result_valid : 1 shows result, 0 shows entry digits
//   seg_an       : active-low anode enables, bit n = digit n
//   seg_seg      : active-low segments, [0]=a .. [6]=g, [7]=dp
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] entry_bcd,
  input  logic [1:0]  cursor,
  input  logic [31:0] result,
  input  logic        result_valid,
  output logic [3:0]  seg_an,
  output logic [7:0]  seg_seg
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic [1:0]         cursor_q;

  logic [31:0] last_cap;
  logic        ovf_pend;
  logic        ovf_reg;
  logic [15:0] bcd_reg;
  logic        cv_busy, cv_done, cv_start;
  logic [15:0] cv_bcd;
  logic        cv_idle, new_val, is_ovf;

  logic [3:0] an_d;
  logic [7:0] seg_d;
  logic [3:0] nib;
  logic       lead_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  // Moving the cursor restarts the blink so the newly selected digit is
  // immediately visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      cursor_q  <= '0;
    end else begin
      cursor_q <= cursor;
      if (cursor != cursor_q) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Capture only while the converter is fully idle, so a result that
  // changes mid-conversion is picked up after the current commit.
  assign cv_idle  = !cv_busy && !ovf_pend;
  assign new_val  = (result != last_cap);
  assign is_ovf   = (result > RESULT_MAX);
  assign cv_start = cv_idle && new_val && !is_ovf;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (cv_start),
    .bin   (result[BIN_BITS-1:0]),
    .busy  (cv_busy),
    .done  (cv_done),
    .bcd   (cv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cap <= '0;
      ovf_pend <= 1'b0;
      ovf_reg  <= 1'b0;
      bcd_reg  <= '0;
    end else begin
      if (cv_idle && new_val) begin
        last_cap <= result;
        ovf_pend <= is_ovf;
      end
      if (ovf_pend) begin
        ovf_reg  <= 1'b1;
        ovf_pend <= 1'b0;
      end
      if (cv_done) begin
        bcd_reg <= cv_bcd;
        ovf_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    an_d       = ~(4'b0001 << digit_idx);
    nib        = '0;
    lead_blank = 1'b0;
    seg_d      = SEG_BLANK;
    if (result_valid) begin
      nib = bcd_reg[{digit_idx, 2'b00} +: 4];
      case (digit_idx)
        2'd3:    lead_blank = (bcd_reg[15:12] == 4'd0);
        2'd2:    lead_blank = (bcd_reg[15:8] == 8'd0);
        2'd1:    lead_blank = (bcd_reg[15:4] == 12'd0);
        default: lead_blank = 1'b0;
      endcase
      if (ovf_reg)
        seg_d = SEG_DASH;
      else if (lead_blank)
        seg_d = SEG_BLANK;
      else
        seg_d = nibble_to_seg(nib);
    end else begin
      nib   = entry_bcd[{digit_idx, 2'b00} +: 4];
      seg_d = nibble_to_seg(nib);
      if (digit_idx == cursor)
        seg_d = blink_on ? (seg_d & 8'h7F) : 8'h7F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_an  <= 4'b1111;
      seg_seg <= 8'hFF;
    end else begin
      seg_an  <= an_d;
      seg_seg <= seg_d;
    end
  end

endmodule
